// File: rtl/spi_frame_receiver.sv
// Receive-side SPI frame parser: command byte, address byte, then WORDS_PER_FRAME
// 32-bit words sent LSB first, each pushed into a downstream FIFO.
module spi_frame_receiver #(
  parameter logic [7:0]  CMD_WRITE       = 8'd2,
  parameter int unsigned WORDS_PER_FRAME = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        frame_active,
  input  logic        fifo_full,
  input  logic        clear_status,
  output logic [31:0] fifo_data,
  output logic        fifo_write,
  output logic [7:0]  frame_address,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic        overflow,
  output logic [7:0]  dropped_words
);

  localparam int unsigned WORD_IDX_W = 8;
  localparam int unsigned ASM_W      = 24;
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [1:0] ERR_BAD_CMD   = 2'd1;
  localparam logic [1:0] ERR_TRUNCATED = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    DISCARD
  } state_t;

  state_t                 state, state_d;
  logic [1:0]             byte_idx, byte_idx_d;
  logic [WORD_IDX_W-1:0]  word_idx, word_idx_d;
  logic [ASM_W-1:0]       assembly, assembly_d;
  logic [31:0]            fifo_data_d;
  logic                   fifo_write_d;
  logic [7:0]             frame_address_d;
  logic                   frame_done_d;
  logic                   frame_error_d;
  logic [1:0]             error_code_d;
  logic                   overflow_d;
  logic [7:0]             dropped_words_d;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte_idx      <= '0;
      word_idx      <= '0;
      assembly      <= '0;
      fifo_data     <= '0;
      fifo_write    <= 1'b0;
      frame_address <= '0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      error_code    <= '0;
      overflow      <= 1'b0;
      dropped_words <= '0;
    end else begin
      state         <= state_d;
      byte_idx      <= byte_idx_d;
      word_idx      <= word_idx_d;
      assembly      <= assembly_d;
      fifo_data     <= fifo_data_d;
      fifo_write    <= fifo_write_d;
      frame_address <= frame_address_d;
      frame_done    <= frame_done_d;
      frame_error   <= frame_error_d;
      error_code    <= error_code_d;
      overflow      <= overflow_d;
      dropped_words <= dropped_words_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    byte_idx_d      = byte_idx;
    word_idx_d      = word_idx;
    assembly_d      = assembly;
    fifo_data_d     = fifo_data;
    fifo_write_d    = 1'b0;
    frame_address_d = frame_address;
    frame_done_d    = 1'b0;
    frame_error_d   = 1'b0;
    error_code_d    = error_code;
    overflow_d      = clear_status ? 1'b0 : overflow;
    dropped_words_d = clear_status ? 8'd0 : dropped_words;

    if (!frame_active) begin
      // Chip-select released: any byte this cycle is ignored
      state_d = IDLE;
      if (state == ADDR || state == DATA) begin
        frame_error_d = 1'b1;
        error_code_d  = ERR_TRUNCATED;
      end
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == CMD_WRITE) begin
            state_d = ADDR;
          end else begin
            state_d       = DISCARD;
            frame_error_d = 1'b1;
            error_code_d  = ERR_BAD_CMD;
          end
        end
        ADDR: begin
          frame_address_d = rx_byte;
          byte_idx_d      = '0;
          word_idx_d      = '0;
          assembly_d      = '0;
          state_d         = DATA;
        end
        DATA: begin
          byte_idx_d = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: assembly_d[7:0]   = rx_byte;
            2'd1: assembly_d[15:8]  = rx_byte;
            2'd2: assembly_d[23:16] = rx_byte;
            default: begin
              // Word complete: publish it even when the FIFO refuses it
              fifo_data_d = {rx_byte, assembly};
              if (fifo_full) begin
                overflow_d = 1'b1;
                if (dropped_words_d != 8'hFF) begin
                  dropped_words_d = dropped_words_d + 8'd1;
                end
              end else begin
                fifo_write_d = 1'b1;
              end
              if (word_idx == LAST_WORD) begin
                frame_done_d = 1'b1;
                state_d      = DONE;
              end else begin
                word_idx_d = word_idx + WORD_IDX_W'(1);
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed self-checking bench for spi_frame_receiver.
module tb_spi_frame_receiver;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_active;
  logic        fifo_full;
  logic        clear_status;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic [7:0]  frame_address;
  logic        frame_done;
  logic        frame_error;
  logic [1:0]  error_code;
  logic        overflow;
  logic [7:0]  dropped_words;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  int          exp_cyc[$];
  int          done_cnt, done_cyc, err_cnt, err_cyc;
  logic        both_seen = 1'b0;

  spi_frame_receiver dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .frame_active  (frame_active),
    .fifo_full     (fifo_full),
    .clear_status  (clear_status),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .frame_address (frame_address),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .error_code    (error_code),
    .overflow      (overflow),
    .dropped_words (dropped_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe output pulses mid-cycle
  always @(negedge clock) begin
    if (reset_n) begin
      if (fifo_write) begin
        wr_q.push_back(fifo_data);
        wr_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (frame_error) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      if (frame_done && frame_error) both_seen = 1'b1;
    end
  end

  function automatic logic [31:0] word_of(input logic [7:0] base, input int w);
    logic [7:0] b;
    b = base + 8'(4 * w);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic drive(input logic v, input logic [7:0] b, input logic act);
    @(negedge clock);
    rx_valid     = v;
    rx_byte      = b;
    frame_active = act;
  endtask

  task automatic idle(input int n, input logic act);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, act);
  endtask

  task automatic mon_clear;
    @(posedge clock);
    wr_q.delete();
    wr_cyc_q.delete();
    exp_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    err_cnt  = 0;
    err_cyc  = -1;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] base, input int ndata);
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, addr, 1'b1);
    for (int i = 0; i < ndata; i++) begin
      drive(1'b1, base + 8'(i), 1'b1);
      if (i % 4 == 3 && i < 32) exp_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; frame_active = 1'b0;
    fifo_full = 1'b0; clear_status = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    n_tests++;
    if ({fifo_data, fifo_write, frame_address, frame_done, frame_error, error_code,
         overflow, dropped_words} !== 54'd0) begin
      n_fail++; $display("FAIL reset_outputs: got data=%h addr=%h ec=%0d ov=%b dr=%0d want all 0",
                         fifo_data, frame_address, error_code, overflow, dropped_words);
    end
  endtask

  task automatic test_normal;
    mon_clear();
    send_frame(8'h00, 8'h00, 32);
    idle(3, 1'b1);
    n_tests++;
    if (wr_q.size() != 8) begin n_fail++; $display("FAIL normal_count: got %0d want 8", wr_q.size()); end
    for (int w = 0; w < 8; w++) begin
      n_tests++;
      if (w >= wr_q.size() || wr_q[w] !== word_of(8'h00, w)) begin
        n_fail++; $display("FAIL normal_word%0d: got %h want %h", w,
                           (w < wr_q.size()) ? wr_q[w] : 32'hx, word_of(8'h00, w));
      end
      n_tests++;
      if (w >= wr_cyc_q.size() || w >= exp_cyc.size() || wr_cyc_q[w] != exp_cyc[w]) begin
        n_fail++; $display("FAIL normal_latency%0d: got cycle %0d want %0d", w,
                           (w < wr_cyc_q.size()) ? wr_cyc_q[w] : -1,
                           (w < exp_cyc.size()) ? exp_cyc[w] : -1);
      end
    end
    n_tests++;
    if (wr_q.size() < 1 || wr_q[0] !== 32'h03020100) begin
      n_fail++; $display("FAIL normal_first: got %h want 03020100", (wr_q.size() > 0) ? wr_q[0] : 32'hx);
    end
    n_tests++;
    if (wr_q.size() < 8 || wr_q[7] !== 32'h1F1E1D1C) begin
      n_fail++; $display("FAIL normal_last: got %h want 1f1e1d1c", (wr_q.size() > 7) ? wr_q[7] : 32'hx);
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL normal_done_count: got %0d want 1", done_cnt); end
    n_tests++;
    if (wr_cyc_q.size() < 8 || done_cyc != wr_cyc_q[7]) begin
      n_fail++; $display("FAIL normal_done_align: got cycle %0d want %0d", done_cyc,
                         (wr_cyc_q.size() > 7) ? wr_cyc_q[7] : -1);
    end
    idle(2, 1'b0);
    n_tests++;
    if (err_cnt != 0) begin n_fail++; $display("FAIL normal_no_error: got %0d errors want 0", err_cnt); end
    n_tests++;
    if (frame_address !== 8'h00) begin n_fail++; $display("FAIL normal_addr: got %h want 00", frame_address); end
  endtask

  task automatic test_bad_cmd;
    int ecyc;
    mon_clear();
    drive(1'b1, 8'h05, 1'b1);
    ecyc = cyc + 1;
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h22, 1'b1);
    drive(1'b1, 8'h33, 1'b1);
    drive(1'b1, 8'h44, 1'b1);
    idle(2, 1'b1);
    n_tests++;
    if (err_cnt != 1 || err_cyc != ecyc) begin
      n_fail++; $display("FAIL badcmd_error: got %0d pulses at %0d want 1 at %0d", err_cnt, err_cyc, ecyc);
    end
    n_tests++;
    if (error_code !== 2'd1) begin n_fail++; $display("FAIL badcmd_code: got %0d want 1", error_code); end
    n_tests++;
    if (wr_q.size() != 0) begin n_fail++; $display("FAIL badcmd_writes: got %0d want 0", wr_q.size()); end
    idle(1, 1'b0);
    mon_clear();
    send_frame(8'h07, 8'h40, 32);
    idle(2, 1'b1);
    n_tests++;
    if (wr_q.size() != 8) begin n_fail++; $display("FAIL badcmd_next_count: got %0d want 8", wr_q.size()); end
    n_tests++;
    if (wr_q.size() < 1 || wr_q[0] !== 32'h43424140) begin
      n_fail++; $display("FAIL badcmd_next_word0: got %h want 43424140", (wr_q.size() > 0) ? wr_q[0] : 32'hx);
    end
    n_tests++;
    if (frame_address !== 8'h07) begin n_fail++; $display("FAIL badcmd_next_addr: got %h want 07", frame_address); end
    n_tests++;
    if (err_cnt != 0 || error_code !== 2'd1) begin
      n_fail++; $display("FAIL badcmd_code_hold: got %0d errors code %0d want 0 errors code 1", err_cnt, error_code);
    end
    idle(1, 1'b0);
  endtask

  task automatic test_truncation;
    mon_clear();
    send_frame(8'h03, 8'h20, 14);
    drive(1'b0, 8'h00, 1'b0);
    idle(2, 1'b0);
    n_tests++;
    if (wr_q.size() != 3) begin n_fail++; $display("FAIL trunc_count: got %0d want 3", wr_q.size()); end
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if (w >= wr_q.size() || wr_q[w] !== word_of(8'h20, w)) begin
        n_fail++; $display("FAIL trunc_word%0d: got %h want %h", w,
                           (w < wr_q.size()) ? wr_q[w] : 32'hx, word_of(8'h20, w));
      end
    end
    n_tests++;
    if (err_cnt != 1 || error_code !== 2'd2) begin
      n_fail++; $display("FAIL trunc_error: got %0d pulses code %0d want 1 pulse code 2", err_cnt, error_code);
    end
    n_tests++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL trunc_no_done: got %0d want 0", done_cnt); end
    mon_clear();
    send_frame(8'h04, 8'h80, 32);
    idle(2, 1'b1);
    n_tests++;
    if (wr_q.size() != 8 || wr_q[0] !== 32'h83828180) begin
      n_fail++; $display("FAIL trunc_next_word0: got %0d writes first %h want 8 writes first 83828180",
                         wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx);
    end
    idle(1, 1'b0);
  endtask

  task automatic test_overflow;
    mon_clear();
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'h09, 1'b1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (i == 12) begin
        n_tests++;
        if (fifo_write !== 1'b0 || fifo_data !== 32'h0B0A0908) begin
          n_fail++; $display("FAIL ovf_drop_slot: got write=%b data=%h want write=0 data=0b0a0908",
                             fifo_write, fifo_data);
        end
      end
      fifo_full = (i == 11);
    end
    idle(2, 1'b1);
    n_tests++;
    if (wr_q.size() != 7) begin n_fail++; $display("FAIL ovf_count: got %0d want 7", wr_q.size()); end
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (k >= wr_q.size() || wr_q[k] !== word_of(8'h00, (k < 2) ? k : k + 1)) begin
        n_fail++; $display("FAIL ovf_word%0d: got %h want %h", k,
                           (k < wr_q.size()) ? wr_q[k] : 32'hx, word_of(8'h00, (k < 2) ? k : k + 1));
      end
    end
    n_tests++;
    if (overflow !== 1'b1 || dropped_words !== 8'd1) begin
      n_fail++; $display("FAIL ovf_status: got ov=%b dr=%0d want ov=1 dr=1", overflow, dropped_words);
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL ovf_done: got %0d want 1", done_cnt); end
    @(negedge clock); clear_status = 1'b1;
    @(negedge clock); clear_status = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || dropped_words !== 8'd0) begin
      n_fail++; $display("FAIL ovf_clear: got ov=%b dr=%0d want ov=0 dr=0", overflow, dropped_words);
    end
    idle(1, 1'b0);
  endtask

  task automatic test_saturation;
    mon_clear();
    fifo_full = 1'b1;
    for (int f = 0; f < 32; f++) begin
      send_frame(8'h01, 8'h00, 32);
      idle(1, 1'b0);
    end
    idle(1, 1'b0);
    n_tests++;
    if (dropped_words !== 8'd255 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sat_count: got dr=%0d ov=%b want dr=255 ov=1", dropped_words, overflow);
    end
    n_tests++;
    if (wr_q.size() != 0 || done_cnt != 32) begin
      n_fail++; $display("FAIL sat_writes: got %0d writes %0d done want 0 writes 32 done", wr_q.size(), done_cnt);
    end
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (i == 4) begin
        n_tests++;
        if (dropped_words !== 8'd1 || overflow !== 1'b1) begin
          n_fail++; $display("FAIL sat_clear_vs_drop: got dr=%0d ov=%b want dr=1 ov=1", dropped_words, overflow);
        end
      end
      clear_status = (i == 3);
    end
    idle(2, 1'b0);
    n_tests++;
    if (dropped_words !== 8'd8) begin n_fail++; $display("FAIL sat_recount: got %0d want 8", dropped_words); end
    fifo_full = 1'b0;
    @(negedge clock); clear_status = 1'b1;
    @(negedge clock); clear_status = 1'b0;
  endtask

  task automatic test_reset_mid;
    mon_clear();
    send_frame(8'h55, 8'h10, 10);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({fifo_data, fifo_write, frame_address, frame_done, frame_error, error_code,
         overflow, dropped_words} !== 54'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got data=%h addr=%h wr=%b want all 0",
                         fifo_data, frame_address, fifo_write);
    end
    rx_valid = 1'b0; frame_active = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    mon_clear();
    send_frame(8'h66, 8'h90, 32);
    idle(2, 1'b1);
    n_tests++;
    if (wr_q.size() != 8) begin n_fail++; $display("FAIL rstmid_count: got %0d want 8", wr_q.size()); end
    for (int w = 0; w < 8; w++) begin
      n_tests++;
      if (w >= wr_q.size() || wr_q[w] !== word_of(8'h90, w)) begin
        n_fail++; $display("FAIL rstmid_word%0d: got %h want %h", w,
                           (w < wr_q.size()) ? wr_q[w] : 32'hx, word_of(8'h90, w));
      end
    end
    n_tests++;
    if (frame_address !== 8'h66) begin n_fail++; $display("FAIL rstmid_addr: got %h want 66", frame_address); end
    idle(1, 1'b0);
  endtask

  task automatic test_back_to_back;
    mon_clear();
    send_frame(8'h01, 8'hA0, 34);
    drive(1'b0, 8'h00, 1'b0);
    send_frame(8'h02, 8'hC0, 32);
    idle(2, 1'b1);
    idle(2, 1'b0);
    n_tests++;
    if (wr_q.size() != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", wr_q.size()); end
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (k >= wr_q.size() || wr_q[k] !== word_of((k < 8) ? 8'hA0 : 8'hC0, k % 8)) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h want %h", k,
                           (k < wr_q.size()) ? wr_q[k] : 32'hx, word_of((k < 8) ? 8'hA0 : 8'hC0, k % 8));
      end
    end
    n_tests++;
    if (done_cnt != 2 || err_cnt != 0) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d done %0d err want 2 done 0 err", done_cnt, err_cnt);
    end
    n_tests++;
    if (frame_address !== 8'h02) begin n_fail++; $display("FAIL b2b_addr: got %h want 02", frame_address); end
  endtask

  task automatic test_exclusive;
    n_tests++;
    if (both_seen !== 1'b0) begin
      n_fail++; $display("FAIL done_error_exclusive: got %b want 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_cmd();
    test_truncation();
    test_overflow();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
